// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
// Contents:
//   DATA_BITS    : payload bits per 8N1 frame
//   rx_state_e   : receiver FSM encoding (IDLE, START, DATA, STOP)
//   baud_ticks() : clock cycles per bit, CLOCK_FREQ/BAUD with integer division
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic int baud_ticks(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous single-bit input
// Ports:
//   clk   in  : sampling clock
//   rst_n in  : asynchronous active-low reset, both flops load RESET_VAL
//   d     in  : asynchronous input
//   q     out : synchronized output, two cycles of latency
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;
  logic meta_d;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
// Ports:
//   clk       in  : system clock, rising edge
//   rst_n     in  : asynchronous active-low reset
//   rx        in  : serial line, asynchronous to clk, idles high
//   rx_data   out : received byte, stable while rx_valid is high
//   rx_valid  out : byte available, held until accepted
//   rx_ready  in  : consumer accepts on rx_valid && rx_ready
//   frame_err out : one-cycle pulse when the stop bit is sampled low
//   overrun   out : one-cycle pulse when a byte lands on an unaccepted byte
//   busy      out : high while a frame is being received
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD       = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BAUD_TICKS = baud_ticks(CLOCK_FREQ, BAUD);
  localparam int HALF       = BAUD_TICKS / 2;

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e state_q, state_d;

  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_p_q, rx_p_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  // One-cycle events raised by the FSM in the stop-sample cycle.
  logic byte_done;
  logic stop_bad;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus bit timing and the data shifter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_p_d    = rx_s;
    byte_done = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Only a true high-to-low transition starts a frame, so a line
        // stuck low (break) cannot retrigger reception.
        if (rx_p_q && !rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to spot
        // the next start edge of a back-to-back frame.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) begin
            byte_done = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Output logic: handshake, byte delivery and error pulses.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // A byte landing in the same cycle the old one is accepted is not an
    // overrun; the old byte has been consumed.
    if (byte_done) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end

    if (stop_bad) begin
      frame_err_d = 1'b1;
    end

    busy = (state_q != RX_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_p_q      <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_p_q      <= rx_p_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

  localparam int CF   = 1600;
  localparam int BD   = 100;
  localparam int BT   = CF / BD;
  localparam int HALF = BT / 2;
  // Cycle in which the outputs show a frame whose start bit was put on the
  // pin in cycle n: 2 sync cycles, 1 to enter START, half bit, 9 bits, +1.
  localparam int LAT  = 2 + 1 + HALF + 9 * BT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLOCK_FREQ(CF),
    .BAUD      (BD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: last byte that should sit in rx_data and whether a
  // delivered byte is still expected to be waiting.
  logic [7:0] last_good = 8'h00;
  bit         mvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) sync_edge();
  endtask

  // acc: the previously delivered byte is consumed no later than the cycle
  // in which this frame completes.
  task automatic expect_frame(input int start, input logic [7:0] b, input logic stop, input bit acc);
    exp_t e;
    bit pend;
    pend  = mvalid && !acc;
    e.cyc = start + LAT;
    if (stop) begin
      e.data    = b;
      e.valid   = 1'b1;
      e.fe      = 1'b0;
      e.ov      = pend;
      last_good = b;
      mvalid    = 1'b1;
    end else begin
      e.data  = last_good;
      e.valid = pend;
      e.fe    = 1'b1;
      e.ov    = 1'b0;
      mvalid  = pend;
    end
    exp_q.push_back(e);
  endtask

  // Drives one 8N1 frame starting in the current cycle; returns after the
  // stop bit with the line high.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx = f[j];
      repeat (BT) sync_edge();
    end
    rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input bit acc);
    expect_frame(cyc, b, stop, acc);
    send_frame(b, stop);
  endtask

  // Monitor: any output event pops one expectation and is compared with it.
  initial begin
    bit   pv;
    bit   pacc;
    exp_t e;
    pv   = 1'b0;
    pacc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv   = 1'b0;
        pacc = 1'b0;
      end else begin
        if (frame_err || overrun || (rx_valid && (!pv || pacc))) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: cycle %0d valid=%0b fe=%0b ov=%0b data=%02h expected none",
                     cyc, rx_valid, frame_err, overrun, rx_data);
          end else begin
            e = exp_q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("rx_data", rx_data, e.data);
            chk("rx_valid", rx_valid, e.valid);
            chk("frame_err", frame_err, e.fe);
            chk("overrun", overrun, e.ov);
          end
        end
        pv   = rx_valid;
        pacc = rx_valid && rx_ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to be done", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    logic [9:0] f;

    // Reset values.
    repeat (3) sync_edge();
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) sync_edge();

    // Clean frame, held until accepted at E+160.
    rx_ready = 1'b0;
    n = cyc;
    frame(8'hA5, 1'b1, 1'b1);
    wait_cyc(n + 2 + 160);
    chk("valid_held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    wait_cyc(n + 2 + 161);
    chk("valid_cleared", rx_valid, 1'b0);
    repeat (5) sync_edge();

    // Glitch shorter than half a bit: false start.
    n = cyc;
    rx = 1'b0;
    wait_cyc(n + 4);
    rx = 1'b1;
    wait_cyc(n + 2 + 8);
    chk("glitch_busy_hi", busy, 1'b1);
    wait_cyc(n + 2 + 9);
    chk("glitch_busy_lo", busy, 1'b0);
    repeat (40) sync_edge();

    // Bad stop bit.
    frame(8'h3C, 1'b0, 1'b1);
    repeat (20) sync_edge();

    // Overrun: second byte lands on the unaccepted first.
    rx_ready = 1'b0;
    frame(8'h11, 1'b1, 1'b1);
    frame(8'h22, 1'b1, 1'b0);
    repeat (4) sync_edge();
    rx_ready = 1'b1;
    repeat (4) sync_edge();

    // Old byte accepted exactly in the completion cycle: no overrun.
    rx_ready = 1'b0;
    frame(8'h33, 1'b1, 1'b1);
    n2 = cyc;
    expect_frame(n2, 8'h44, 1'b1, 1'b1);
    fork
      send_frame(8'h44, 1'b1);
      begin
        wait_cyc(n2 + LAT - 1);
        rx_ready = 1'b1;
        wait_cyc(n2 + LAT);
        rx_ready = 1'b0;
      end
    join
    rx_ready = 1'b1;
    repeat (4) sync_edge();

    // Reset during data bit 3, then a clean frame.
    n = cyc;
    f = {1'b1, 8'hC3, 1'b0};
    for (int k = 0; k < 70; k++) begin
      rx = f[k / BT];
      sync_edge();
    end
    chk("midframe_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    rx = 1'b1;
    repeat (3) sync_edge();
    rst_n = 1'b1;
    last_good = 8'h00;
    mvalid = 1'b0;
    repeat (3) sync_edge();
    frame(8'h5A, 1'b1, 1'b1);
    repeat (10) sync_edge();

    // Transmitter-style back-to-back stream.
    frame(8'h00, 1'b1, 1'b1);
    frame(8'hFF, 1'b1, 1'b1);
    frame(8'h55, 1'b1, 1'b1);
    repeat (10) sync_edge();

    // Random frames, gaps and occasional bad stop bits.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      frame(b, stop, 1'b1);
      // A low stop bit needs high time before the next start edge.
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      if (!stop && gap < 2) gap = 2;
      repeat (gap) sync_edge();
    end

    repeat (200) sync_edge();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
